alu_result_stage: RTL and testbench

// - Downstream of the 32-bit ALU: captures RES/Z/C/N each accepted op into a small in-order FIFO, presents them to writeback with valid/ready.
// - Owns the architectural flags register (Z,C,N); evaluates the branch condition for the sequencer from committed flags.
// - Decouples ALU timing from writeback stalls, so no ALU result is dropped or duplicated.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_result_fifo.sv | 78 +++++++
 rtl/alu_result_stage.sv | 83 ++++++++
 tb/tb_alu_result_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: branch condition encoding and
// bit positions of the architectural flags inside the {N,C,Z} register.
package alu_pkg;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_CS     = 3'd3,
    COND_CC     = 3'd4,
    COND_MI     = 3'd5,
    COND_PL     = 3'd6,
    COND_NEVER  = 3'd7
  } cond_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;

endpackage

// File: rtl/alu_result_fifo.sv
// In-order FIFO of {dest, result} pairs between the ALU and writeback.
// The full flag is registered alongside the count so the upstream ready never sees a combinational path from pop.
module alu_result_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEST_BITS = 5,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_res,
  input  logic [DEST_BITS-1:0] push_dest,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_res,
  output logic [DEST_BITS-1:0] head_dest,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST  = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0]     mem_res  [DEPTH];
  logic [DEST_BITS-1:0] mem_dest [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full_q;
  logic                 do_push;
  logic                 do_pop;

  // Guard both sides locally so a misbehaving neighbour cannot overflow or underflow.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & (count != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_res[wr_ptr]  <= push_res;
      mem_dest[wr_ptr] <= push_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10: begin
          count  <= count + 1'b1;
          full_q <= (count == CNT_ALMOST);
        end
        2'b01: begin
          count  <= count - 1'b1;
          full_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign empty     = (count == '0);
  assign full      = full_q;
  // Mask the head while empty so stale or uninitialised storage never leaks out.
  assign head_res  = empty ? '0 : mem_res[rd_ptr];
  assign head_dest = empty ? '0 : mem_dest[rd_ptr];

  // Sanity tie between the two views of fullness.
  logic unused_ok;
  assign unused_ok = (count == CNT_FULL) ~^ full_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results for writeback, commits flags at accept time
// and evaluates the sequencer branch condition from the committed flags.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEST_BITS = 5,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 CLK,
  input  logic                 N_RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     IN_RES,
  input  logic                 IN_Z,
  input  logic                 IN_C,
  input  logic                 IN_N,
  input  logic                 IN_FLAGS_WE,
  input  logic [DEST_BITS-1:0] IN_DEST,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic [DEST_BITS-1:0] OUT_DEST,
  input  logic [2:0]           COND,
  output logic                 COND_TRUE,
  output logic [2:0]           FLAGS
);

  logic       full;
  logic       empty;
  logic       accept;
  logic [2:0] flags_q;

  assign IN_READY  = ~full;
  assign OUT_VALID = ~empty;
  assign accept    = IN_VALID & ~full;

  alu_result_fifo #(
    .WIDTH     (WIDTH),
    .DEST_BITS (DEST_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .n_rst     (N_RST),
    .push      (accept),
    .push_res  (IN_RES),
    .push_dest (IN_DEST),
    .pop       (OUT_READY),
    .head_res  (OUT_DATA),
    .head_dest (OUT_DEST),
    .full      (full),
    .empty     (empty)
  );

  // Flags commit at accept so branches are not delayed by writeback stalls.
  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      flags_q <= '0;
    end else if (accept && IN_FLAGS_WE) begin
      flags_q[FLAG_N] <= IN_N;
      flags_q[FLAG_C] <= IN_C;
      flags_q[FLAG_Z] <= IN_Z;
    end
  end

  assign FLAGS = flags_q;

  always_comb begin
    COND_TRUE = 1'b0;
    case (cond_t'(COND))
      COND_ALWAYS: COND_TRUE = 1'b1;
      COND_EQ:     COND_TRUE = flags_q[FLAG_Z];
      COND_NE:     COND_TRUE = ~flags_q[FLAG_Z];
      COND_CS:     COND_TRUE = flags_q[FLAG_C];
      COND_CC:     COND_TRUE = ~flags_q[FLAG_C];
      COND_MI:     COND_TRUE = flags_q[FLAG_N];
      COND_PL:     COND_TRUE = ~flags_q[FLAG_N];
      COND_NEVER:  COND_TRUE = 1'b0;
      default:     COND_TRUE = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: queue-based reference model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_alu_result_stage;

  localparam int WIDTH     = 32;
  localparam int DEST_BITS = 5;
  localparam int DEPTH     = 2;

  logic                 CLK = 1'b0;
  logic                 N_RST;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [WIDTH-1:0]     IN_RES;
  logic                 IN_Z, IN_C, IN_N;
  logic                 IN_FLAGS_WE;
  logic [DEST_BITS-1:0] IN_DEST;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [WIDTH-1:0]     OUT_DATA;
  logic [DEST_BITS-1:0] OUT_DEST;
  logic [2:0]           COND;
  logic                 COND_TRUE;
  logic [2:0]           FLAGS;

  int vectors    = 0;
  int miscompares = 0;

  alu_result_stage #(
    .WIDTH     (WIDTH),
    .DEST_BITS (DEST_BITS),
    .DEPTH     (DEPTH)
  ) dut (
    .CLK         (CLK),
    .N_RST       (N_RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_RES      (IN_RES),
    .IN_Z        (IN_Z),
    .IN_C        (IN_C),
    .IN_N        (IN_N),
    .IN_FLAGS_WE (IN_FLAGS_WE),
    .IN_DEST     (IN_DEST),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .OUT_DEST    (OUT_DEST),
    .COND        (COND),
    .COND_TRUE   (COND_TRUE),
    .FLAGS       (FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of {dest,res}, flags, and a ready that is
  // recomputed from occupancy after each edge.
  logic [DEST_BITS+WIDTH-1:0] mq[$];
  logic [2:0] mflags = 3'b000;
  logic       mready = 1'b1;
  bit         checking = 1'b0;

  function automatic logic exp_cond(input logic [2:0] c, input logic [2:0] f);
    int idx;
    if (c == 3'd0) return 1'b1;
    if (c == 3'd7) return 1'b0;
    idx = (int'(c) - 1) / 2;      // 1,2 -> Z ; 3,4 -> C ; 5,6 -> N
    return f[idx] ^ ~c[0];        // even selects the negated flag
  endfunction

  always @(posedge CLK) begin : model
    bit acc;
    bit pop;
    if (!N_RST) begin
      mq.delete();
      mflags   = 3'b000;
      mready   = 1'b1;
      checking = 1'b1;
    end else begin
      acc = IN_VALID && mready;
      pop = (mq.size() > 0) && OUT_READY;
      if (acc && IN_FLAGS_WE) mflags = {IN_N, IN_C, IN_Z};
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({IN_DEST, IN_RES});
      mready = (mq.size() < DEPTH);
    end
  end

  always @(negedge CLK) begin : compare
    logic [DEST_BITS+WIDTH-1:0] head;
    if (checking) begin
      head = (mq.size() > 0) ? mq[0] : '0;
      chk("in_ready",  32'(IN_READY),  32'(mready));
      chk("out_valid", 32'(OUT_VALID), 32'(mq.size() > 0));
      chk("out_data",  OUT_DATA,       head[WIDTH-1:0]);
      chk("out_dest",  32'(OUT_DEST),  32'(head[DEST_BITS+WIDTH-1:WIDTH]));
      chk("flags",     32'(FLAGS),     32'(mflags));
      chk("cond_true", 32'(COND_TRUE), 32'(exp_cond(COND, mflags)));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic z, input logic c,
                       input logic n, input logic we, input logic [4:0] dest);
    IN_VALID = v; IN_RES = res; IN_Z = z; IN_C = c; IN_N = n;
    IN_FLAGS_WE = we; IN_DEST = dest;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [2:0]  nzc;   // {N,C,Z}
    logic        we;
    logic [4:0]  dest;
    logic        rdy;
    logic [2:0]  cond;
  } vec_t;

  vec_t burst[10] = '{
    '{1'b1, 32'h0000_1000, 3'b010, 1'b1, 5'd4,  1'b1, 3'd3},
    '{1'b1, 32'h8000_0000, 3'b100, 1'b1, 5'd5,  1'b0, 3'd5},
    '{1'b1, 32'h0000_0001, 3'b000, 1'b0, 5'd6,  1'b0, 3'd6},
    '{1'b1, 32'h0000_0002, 3'b001, 1'b1, 5'd7,  1'b1, 3'd1},
    '{1'b0, 32'hDEAD_BEEF, 3'b111, 1'b1, 5'd8,  1'b1, 3'd2},
    '{1'b1, 32'h1234_5678, 3'b011, 1'b1, 5'd9,  1'b1, 3'd4},
    '{1'b1, 32'h0BAD_F00D, 3'b000, 1'b1, 5'd10, 1'b0, 3'd7},
    '{1'b1, 32'h5555_AAAA, 3'b110, 1'b1, 5'd11, 1'b0, 3'd0},
    '{1'b0, 32'h0,         3'b000, 1'b0, 5'd0,  1'b1, 3'd3},
    '{1'b0, 32'h0,         3'b000, 1'b0, 5'd0,  1'b1, 3'd6}
  };

  initial begin
    N_RST = 1'b0; OUT_READY = 1'b0; COND = 3'd0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Reset held two cycles
    step(); step();
    chk("rst_in_ready",  32'(IN_READY),  32'd1);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_flags",     32'(FLAGS),     32'd0);
    chk("rst_cond_true", 32'(COND_TRUE), 32'd1);
    chk("rst_out_data",  OUT_DATA,       32'd0);
    N_RST = 1'b1;

    // Single op
    OUT_READY = 1'b1; COND = 3'd1;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("single_valid", 32'(OUT_VALID), 32'd1);
    chk("single_data",  OUT_DATA,       32'd0);
    chk("single_dest",  32'(OUT_DEST),  32'd3);
    chk("single_flags", 32'(FLAGS),     32'b001);
    chk("single_eq",    32'(COND_TRUE), 32'd1);
    step();
    chk("single_drained", 32'(OUT_VALID), 32'd0);

    // Fill and stall, third push refused
    OUT_READY = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1); step();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2); step();
    chk("full_ready", 32'(IN_READY), 32'd0);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9); step();
    chk("full_ready_hold", 32'(IN_READY), 32'd0);
    chk("full_head",       OUT_DATA,      32'h11);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    OUT_READY = 1'b1;
    #1 chk("pop_full_ready_still_low", 32'(IN_READY), 32'd0);
    step();
    chk("drain_head2",  OUT_DATA,       32'h22);
    chk("drain_dest2",  32'(OUT_DEST),  32'd2);
    chk("drain_ready",  32'(IN_READY),  32'd1);
    step();
    chk("drain_empty",  32'(OUT_VALID), 32'd0);
    chk("drain_data0",  OUT_DATA,       32'd0);

    // Simultaneous push and pop at count 1
    OUT_READY = 1'b0;
    drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10); step();
    chk("sim_head_aa", OUT_DATA, 32'hAA);
    OUT_READY = 1'b1;
    drive(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    OUT_READY = 1'b0;
    chk("sim_head_bb", OUT_DATA,        32'hBB);
    chk("sim_valid",   32'(OUT_VALID),  32'd1);
    chk("sim_ready",   32'(IN_READY),   32'd1);
    OUT_READY = 1'b1;
    step();
    chk("sim_drained", 32'(OUT_VALID), 32'd0);

    // Flags ordering: second op does not write flags
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12); step();
    drive(1'b1, 32'h1,         1'b0, 1'b1, 1'b0, 1'b0, 5'd13); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("flg_value", 32'(FLAGS), 32'b100);
    COND = 3'd5; #1 chk("flg_mi", 32'(COND_TRUE), 32'd1);
    COND = 3'd3; #1 chk("flg_cs", 32'(COND_TRUE), 32'd0);
    COND = 3'd7; #1 chk("flg_never", 32'(COND_TRUE), 32'd0);
    COND = 3'd6; #1 chk("flg_pl", 32'(COND_TRUE), 32'd0);
    for (int i = 0; i < 8; i++) begin
      COND = 3'(i);
      step();
    end

    // Reset mid-operation with a push in the reset cycle
    OUT_READY = 1'b0;
    drive(1'b1, 32'h66, 1'b1, 1'b1, 1'b0, 1'b1, 5'd14); step();
    drive(1'b1, 32'h67, 1'b0, 1'b1, 1'b1, 1'b1, 5'd15); step();
    N_RST = 1'b0; OUT_READY = 1'b1;
    drive(1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 1'b1, 5'd16); step();
    N_RST = 1'b1; OUT_READY = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("midrst_valid", 32'(OUT_VALID), 32'd0);
    chk("midrst_ready", 32'(IN_READY),  32'd1);
    chk("midrst_flags", 32'(FLAGS),     32'd0);
    OUT_READY = 1'b1;
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 5'd17); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("midrst_one_entry", OUT_DATA, 32'h55);
    step();
    chk("midrst_count0", 32'(OUT_VALID), 32'd0);

    // Mixed burst with intermittent stalls, checked by the model
    foreach (burst[i]) begin
      drive(burst[i].v, burst[i].res, burst[i].nzc[0], burst[i].nzc[1], burst[i].nzc[2],
            burst[i].we, burst[i].dest);
      OUT_READY = burst[i].rdy;
      COND = burst[i].cond;
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    OUT_READY = 1'b1;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
